// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU dispatcher: target IDs, FSM states and the
// saturating byte-index helper.
package mcu_pkg;

    // Target ID values carried in the first byte of a transfer.
    localparam logic [7:0] TGT_STAT = 8'd0;
    localparam logic [7:0] TGT_HID  = 8'd1;
    localparam logic [7:0] TGT_OSD  = 8'd2;
    localparam logic [7:0] TGT_SDC  = 8'd3;

    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        STAT = 2'd2,
        DROP = 2'd3
    } state_t;

    // Payload index counter that sticks at its maximum value.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (&idx) ? idx : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/irq_collector.sv
// Interrupt edge detector and pending register.
// Ports: clk, reset (sync, active-high), irq_in (level requests),
//        clear (bits to clear this cycle), pending (latched rising edges).
module irq_collector #(
    parameter int unsigned NUM_TGT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_TGT-1:0] irq_in,
    input  logic [NUM_TGT-1:0] clear,
    output logic [NUM_TGT-1:0] pending
);

    logic [NUM_TGT-1:0] irq_q;

    // A new rising edge wins over a simultaneous clear of the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq_in;
            pending <= (pending & ~clear) | (irq_in & ~irq_q);
        end
    end

endmodule

// File: rtl/mcu_dispatch.sv
// MCU byte-stream dispatcher: routes transfers to external targets, serves
// status reads and aggregates target interrupts.
// Ports: clk, reset (sync, active-high); data_in_strobe/data_in_start/data_in
//        from the MCU, data_out back to it; tgt_strobe/tgt_start/tgt_data to
//        targets, tgt_dout from them; irq_in from targets, mcu_irq to the MCU.
module mcu_dispatch
    import mcu_pkg::*;
#(
    parameter logic [7:0]  CORE_ID = 8'h5c,
    parameter int unsigned NUM_TGT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_in_strobe,
    input  logic                 data_in_start,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic [NUM_TGT-1:0]   tgt_strobe,
    output logic                 tgt_start,
    output logic [7:0]           tgt_data,
    input  logic [8*NUM_TGT-1:0] tgt_dout,
    input  logic [NUM_TGT-1:0]   irq_in,
    output logic                 mcu_irq
);

    state_t             state;
    logic [7:0]         tgt_id;
    logic [IDX_W-1:0]   idx;
    logic [NUM_TGT-1:0] pending;
    logic [NUM_TGT-1:0] clear_c;
    logic [NUM_TGT-1:0] tgt_sel_c;
    logic [7:0]         sel_dout_c;
    logic [7:0]         stat_byte_c;
    logic               start_c;
    logic               payload_c;

    assign start_c   = data_in_strobe & data_in_start;
    assign payload_c = data_in_strobe & ~data_in_start;

    // Decode the latched target ID into a one-hot select and its return byte.
    always_comb begin
        tgt_sel_c  = '0;
        sel_dout_c = 8'h00;
        for (int i = 0; i < int'(NUM_TGT); i++) begin
            if (tgt_id == 8'(i + 1)) begin
                tgt_sel_c[i] = 1'b1;
                sel_dout_c   = tgt_dout[8*i +: 8];
            end
        end
    end

    // Status byte for the current payload index.
    always_comb begin
        stat_byte_c = 8'h00;
        if (idx == IDX_W'(0)) begin
            stat_byte_c = CORE_ID;
        end else if (idx == IDX_W'(1)) begin
            stat_byte_c = 8'(pending);
        end
    end

    // Reading the pending mask acknowledges exactly what was reported.
    assign clear_c = (state == STAT && payload_c && idx == IDX_W'(1)) ? pending : '0;

    irq_collector #(
        .NUM_TGT (NUM_TGT)
    ) u_irq_collector (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .clear   (clear_c),
        .pending (pending)
    );

    // Transfer FSM with registered outputs; a start strobe restarts from any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tgt_id     <= 8'h00;
            idx        <= '0;
            data_out   <= 8'h00;
            tgt_strobe <= '0;
            tgt_start  <= 1'b0;
            tgt_data   <= 8'h00;
            mcu_irq    <= 1'b0;
        end else begin
            tgt_strobe <= '0;
            tgt_start  <= 1'b0;
            mcu_irq    <= |pending;
            if (start_c) begin
                tgt_id   <= data_in;
                idx      <= '0;
                data_out <= 8'h00;
                if (data_in == TGT_STAT) begin
                    state <= STAT;
                end else if (data_in <= 8'(NUM_TGT)) begin
                    state <= FWD;
                end else begin
                    state <= DROP;
                end
            end else begin
                case (state)
                    IDLE: data_out <= 8'h00;
                    FWD: begin
                        data_out <= sel_dout_c;
                        if (payload_c) begin
                            tgt_strobe <= tgt_sel_c;
                            tgt_start  <= (idx == '0);
                            tgt_data   <= data_in;
                            idx        <= idx_inc(idx);
                        end
                    end
                    STAT: begin
                        if (payload_c) begin
                            data_out <= stat_byte_c;
                            idx      <= idx_inc(idx);
                        end
                    end
                    DROP: data_out <= 8'h00;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcu_dispatch.sv
// Directed self-checking bench for mcu_dispatch.
module tb_mcu_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_in_strobe;
    logic        data_in_start;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [2:0]  tgt_strobe;
    logic        tgt_start;
    logic [7:0]  tgt_data;
    logic [23:0] tgt_dout;
    logic [2:0]  irq_in;
    logic        mcu_irq;

    int checks   = 0;
    int failures = 0;

    mcu_dispatch #(
        .CORE_ID (8'h5c),
        .NUM_TGT (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in_strobe (data_in_strobe),
        .data_in_start  (data_in_start),
        .data_in        (data_in),
        .data_out       (data_out),
        .tgt_strobe     (tgt_strobe),
        .tgt_start      (tgt_start),
        .tgt_data       (tgt_data),
        .tgt_dout       (tgt_dout),
        .irq_in         (irq_in),
        .mcu_irq        (mcu_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait n rising edges, then sit 1 time unit past the last one.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One MCU byte: strobe held across exactly one rising edge.
    task automatic send(input logic st, input logic [7:0] d);
        data_in        = d;
        data_in_start  = st;
        data_in_strobe = 1'b1;
        @(posedge clk);
        #1;
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
        data_in        = 8'h00;
        tgt_dout       = {8'h33, 8'h22, 8'h11};
        irq_in         = 3'b000;
        idle(2);
        reset = 1'b0;
        idle(1);

        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_tgt_strobe", 32'(tgt_strobe), 32'h0);
        chk("rst_tgt_start", 32'(tgt_start), 32'h0);
        chk("rst_tgt_data", 32'(tgt_data), 32'h00);
        chk("rst_mcu_irq", 32'(mcu_irq), 32'h0);

        // hid transfer: two payload bytes
        send(1'b1, 8'h01);
        idle(3);
        send(1'b0, 8'h01);
        chk("hid1_strobe", 32'(tgt_strobe), 32'h1);
        chk("hid1_start", 32'(tgt_start), 32'h1);
        chk("hid1_data", 32'(tgt_data), 32'h01);
        idle(1);
        chk("hid1_strobe_off", 32'(tgt_strobe), 32'h0);
        chk("hid1_start_off", 32'(tgt_start), 32'h0);
        chk("hid_dout", 32'(data_out), 32'h11);
        idle(2);
        send(1'b0, 8'h23);
        chk("hid2_strobe", 32'(tgt_strobe), 32'h1);
        chk("hid2_start", 32'(tgt_start), 32'h0);
        chk("hid2_data", 32'(tgt_data), 32'h23);
        idle(1);
        chk("hid2_strobe_off", 32'(tgt_strobe), 32'h0);
        idle(2);

        // status transfer with nothing pending
        send(1'b1, 8'h00);
        idle(3);
        send(1'b0, 8'h00);
        chk("stat0_id", 32'(data_out), 32'h5c);
        chk("stat0_nostrobe", 32'(tgt_strobe), 32'h0);
        idle(3);
        send(1'b0, 8'h00);
        chk("stat0_mask", 32'(data_out), 32'h00);
        idle(3);

        // irq_in[1] rises, read and clear
        irq_in[1] = 1'b1;
        idle(2);
        chk("irq1_mcu_irq", 32'(mcu_irq), 32'h1);
        send(1'b1, 8'h00);
        idle(3);
        send(1'b0, 8'h00);
        chk("irq1_stat_id", 32'(data_out), 32'h5c);
        idle(3);
        send(1'b0, 8'h00);
        chk("irq1_mask", 32'(data_out), 32'h02);
        idle(2);
        chk("irq1_cleared", 32'(mcu_irq), 32'h0);
        idle(1);
        send(1'b0, 8'h00);
        chk("stat_idx2", 32'(data_out), 32'h00);
        idle(3);

        // irq_in[2] re-rises in the same cycle as its clear
        irq_in[2] = 1'b1;
        idle(2);
        irq_in[2] = 1'b0;
        idle(1);
        chk("irq2_mcu_irq", 32'(mcu_irq), 32'h1);
        send(1'b1, 8'h00);
        idle(3);
        send(1'b0, 8'h00);
        idle(3);
        irq_in[2] = 1'b1;
        send(1'b0, 8'h00);
        chk("irq2_mask", 32'(data_out), 32'h04);
        idle(2);
        chk("irq2_still_pending", 32'(mcu_irq), 32'h1);
        idle(1);
        send(1'b1, 8'h00);
        idle(3);
        send(1'b0, 8'h00);
        idle(3);
        send(1'b0, 8'h00);
        chk("irq2_reread", 32'(data_out), 32'h04);
        idle(2);
        chk("irq2_cleared", 32'(mcu_irq), 32'h0);
        idle(1);

        // unknown target is dropped, then osd resumes
        send(1'b1, 8'h07);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 8'(8'h50 + i));
            chk("drop_strobe", 32'(tgt_strobe), 32'h0);
            chk("drop_dout", 32'(data_out), 32'h00);
            idle(3);
        end
        send(1'b1, 8'h02);
        idle(3);
        send(1'b0, 8'h44);
        chk("osd_strobe", 32'(tgt_strobe), 32'h2);
        chk("osd_start", 32'(tgt_start), 32'h1);
        chk("osd_data", 32'(tgt_data), 32'h44);
        idle(2);
        chk("osd_dout", 32'(data_out), 32'h22);
        idle(1);

        // reset mid hid transfer
        send(1'b1, 8'h01);
        idle(3);
        send(1'b0, 8'haa);
        idle(3);
        send(1'b0, 8'hbb);
        chk("hidb_strobe", 32'(tgt_strobe), 32'h1);
        chk("hidb_start", 32'(tgt_start), 32'h0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("mid_rst_strobe", 32'(tgt_strobe), 32'h0);
        chk("mid_rst_data", 32'(tgt_data), 32'h00);
        chk("mid_rst_dout", 32'(data_out), 32'h00);
        chk("mid_rst_irq", 32'(mcu_irq), 32'h0);
        // start without strobe must not open a transfer
        data_in_start = 1'b1;
        data_in       = 8'h01;
        idle(1);
        data_in_start = 1'b0;
        idle(2);
        send(1'b0, 8'hcc);
        chk("post_rst_strobe", 32'(tgt_strobe), 32'h0);
        chk("post_rst_data", 32'(tgt_data), 32'h00);
        idle(1);
        chk("post_rst_dout", 32'(data_out), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcu_dispatch.md
MCU_DISPATCH -- requirements
Module: mcu_dispatch

Interface
REQ-001 Parameter: CORE_ID, 8'h5c, byte returned at index 0 of a status transfer.
REQ-002 Parameter: NUM_TGT, 3, number of external targets (IDs 1..NUM_TGT: 1=hid, 2=osd, 3=sdc).
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 data_in_strobe  in  1  one-cycle pulse per MCU byte.
REQ-006 data_in_start  in  1  qualifies a strobe as the first byte of a transfer.
REQ-007 data_in  in  8  MCU byte.
REQ-008 data_out  out  8  byte returned to MCU, registered.
REQ-009 tgt_strobe  out  NUM_TGT  per-target forwarded strobe, one-hot or zero.
REQ-010 tgt_start  out  1  marks first forwarded byte, valid with any tgt_strobe bit.
REQ-011 tgt_data  out  8  forwarded byte, registered.
REQ-012 tgt_dout  in  8*NUM_TGT  per-target return bytes, target n in bits [8n-1:8n-8].
REQ-013 irq_in  in  NUM_TGT  per-target interrupt request, level.
REQ-014 mcu_irq  out  1  high while any interrupt is pending, registered.

Function
REQ-015 Transfer format: [target ID byte, start=1][payload bytes...]; the first payload byte is forwarded with tgt_start=1.
REQ-016 FSM states: IDLE, FWD, STAT, DROP.
REQ-017 Any strobe with start, in any state, latches data_in as target ID, clears byte index, and moves to FWD (ID 1..NUM_TGT), STAT (ID 0) or DROP (other).
REQ-018 A start received mid-transfer aborts the current transfer; the old target receives no further strobes.
REQ-019 Strobe without start in IDLE is ignored; start without strobe is ignored.
REQ-020 FWD: each payload strobe drives tgt_strobe[ID-1] high for exactly one cycle, one cycle after data_in_strobe, with tgt_data=data_in.
REQ-021 FWD: tgt_start=1 on the first forwarded byte only, 0 otherwise.
REQ-022 FWD: data_out registers the selected target's tgt_dout every cycle, so a byte produced by a target is visible at most 3 clocks after the MCU strobe; MCU strobe spacing is at least 4 clocks.
REQ-023 STAT: payload index 0 returns CORE_ID, index 1 returns the zero-extended pending mask, indices >=2 return 8'h00; the index saturates at 15.
REQ-024 STAT: the strobe at index 1 clears the pending bits it reported.
REQ-025 DROP: bytes are discarded, no tgt_strobe, data_out=8'h00 until the next start.
REQ-026 IDLE: data_out=8'h00.
REQ-027 irq_in is registered once; each rising edge sets its pending bit.
REQ-028 A set and a clear of the same pending bit in one cycle leave the bit set.
REQ-029 mcu_irq = OR of pending, registered (one cycle after pending changes).

Reset
REQ-030 Reset sets state=IDLE, data_out=0, tgt_strobe=0, tgt_start=0, tgt_data=0, pending=0, mcu_irq=0, byte index=0, and the irq_in history register=0.
REQ-031 Reset asserted mid-transfer ends the transfer immediately; no tgt_strobe is issued in the cycle after reset.

Structure
REQ-032 Shared package mcu_pkg holds the target ID constants (STAT=0, HID=1, OSD=2, SDC=3) and the FSM state enum.
REQ-033 The edge-detect and pending logic sits in one sub-module, irq_collector (inputs irq_in and clear mask; output pending).

Verification
REQ-034 Stimulus: start+8'h01, then 8'h01, 8'h23 -> tgt_strobe=3'b001 twice, the first with tgt_start=1 and tgt_data=8'h01, the second with tgt_data=8'h23, each one cycle after its input strobe.
REQ-035 Stimulus: start+8'h00, then two strobes -> data_out=8'h5c after the first and 8'h00 (no pending) after the second.
REQ-036 Stimulus: irq_in[1] rises; then a status transfer -> mcu_irq=1; the index-1 read returns 8'h02; mcu_irq=0 afterwards.
REQ-037 Stimulus: irq_in[2] rises in the same cycle as the index-1 clear of bit 2 -> bit 2 remains pending and mcu_irq stays 1.
REQ-038 Stimulus: start+8'h07 with 3 payload bytes -> no tgt_strobe and data_out=0; then start+8'h02 -> forwarding to the osd target resumes.
REQ-039 Stimulus: reset pulsed after the second payload byte of a hid transfer -> all outputs are 0, and a following non-start strobe is ignored.
